// File: rtl/aurora_rx_pkg.sv
// rtl/aurora_rx_pkg.sv - shared constants, block class and lane state types for the Aurora RX block decoder
package aurora_rx_pkg;

    localparam logic [7:0] BTF_IDLE  = 8'h78;
    localparam logic [7:0] BTF_USERK = 8'hD2;
    localparam logic [1:0] HDR_DATA  = 2'b01;
    localparam logic [1:0] HDR_CTRL  = 2'b10;

    typedef enum logic [2:0] {DATA, USERK, IDLE, CTRL, BAD} blk_class_t;
    typedef enum logic {DOWN, UP} lane_state_t;

    function automatic blk_class_t classify(input logic [1:0] hdr, input logic [7:0] btf);
        blk_class_t c;
        c = BAD;
        if (hdr == HDR_DATA) begin
            c = DATA;
        end else if (hdr == HDR_CTRL) begin
            if (btf == BTF_IDLE)       c = IDLE;
            else if (btf == BTF_USERK) c = USERK;
            else                       c = CTRL;
        end
        return c;
    endfunction

endpackage

// File: rtl/aurora_rx_sync_fifo.sv
// rtl/aurora_rx_sync_fifo.sv - single-clock first-word-fall-through FIFO with synchronous flush
module aurora_rx_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot the write lands in.
    assign do_wr = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/aurora_rx_block_decoder.sv
// rtl/aurora_rx_block_decoder.sv - block classifier, lane-up FSM and output FIFO; AURORA_RX_STATS_EN adds class counters
module aurora_rx_block_decoder
    import aurora_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LOCK_CNT   = 32,
    parameter int ERR_MAX    = 8,
    parameter int ERR_WINDOW = 64
) (
    input  logic        clk_rx_i,
    input  logic        rst_n_i,
    input  logic [63:0] rx_data_i,
    input  logic [1:0]  rx_header_i,
    input  logic        rx_valid_i,
    output logic [63:0] out_data_o,
    output logic        out_type_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        lane_up_o,
    output logic        overflow_o,
`ifdef AURORA_RX_STATS_EN
    output logic [31:0] stat_data_o,
    output logic [31:0] stat_userk_o,
    output logic [31:0] stat_idle_o,
    output logic [31:0] stat_ctrl_o,
    output logic [31:0] stat_bad_o,
    output logic [31:0] stat_drop_o,
`endif
    output logic        hdr_err_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_MAX + 1);
    localparam int WW = $clog2(ERR_WINDOW + 1);

    lane_state_t state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [EW-1:0] err_q, err_d;
    logic [WW-1:0] win_q, win_d;
    logic          push, flush, pop, drop;
    logic          fifo_empty, fifo_full;
    logic [64:0]   fifo_rd;
    logic          ovf_q, hdr_err_q;
    blk_class_t    cls;

    assign cls = classify(rx_header_i, rx_data_i[63:56]);

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= DOWN;
            good_q    <= '0;
            err_q     <= '0;
            win_q     <= '0;
            ovf_q     <= 1'b0;
            hdr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            err_q     <= err_d;
            win_q     <= win_d;
            hdr_err_q <= rx_valid_i && (cls == BAD);
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = err_q;
        win_d   = win_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (rx_valid_i) begin
            case (state_q)
                DOWN: begin
                    if (cls == BAD) begin
                        good_d = '0;
                    end else if (good_q >= GW'(LOCK_CNT - 1)) begin
                        state_d = UP;
                        good_d  = '0;
                        err_d   = '0;
                        win_d   = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                UP: begin
                    if (cls == BAD) begin
                        win_d = '0;
                        if (err_q >= EW'(ERR_MAX - 1)) begin
                            state_d = DOWN;
                            flush   = 1'b1;
                            err_d   = '0;
                            good_d  = '0;
                        end else begin
                            err_d = err_q + 1'b1;
                        end
                    end else begin
                        // A full window of clean blocks forgives earlier header errors.
                        if (win_q >= WW'(ERR_WINDOW - 1)) begin
                            win_d = '0;
                            err_d = '0;
                        end else begin
                            win_d = win_q + 1'b1;
                        end
                        push = (cls == DATA) || (cls == USERK);
                    end
                end
                default: state_d = DOWN;
            endcase
        end
    end

    assign pop  = out_ready_i && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    aurora_rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (65)
    ) u_fifo (
        .clk     (clk_rx_i),
        .rst_n   (rst_n_i),
        .flush   (flush),
        .wr_en   (push),
        .wr_data ({cls == USERK, rx_data_i}),
        .rd_en   (out_ready_i),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_empty ? 64'd0 : fifo_rd[63:0];
    assign out_type_o  = !fifo_empty && fifo_rd[64];
    assign lane_up_o   = (state_q == UP);
    assign overflow_o  = ovf_q;
    assign hdr_err_o   = hdr_err_q;

`ifdef AURORA_RX_STATS_EN
    logic [31:0] s_data, s_userk, s_idle, s_ctrl, s_bad, s_drop;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_data  <= '0;
            s_userk <= '0;
            s_idle  <= '0;
            s_ctrl  <= '0;
            s_bad   <= '0;
            s_drop  <= '0;
        end else begin
            s_data  <= sat_inc(s_data,  rx_valid_i && cls == DATA);
            s_userk <= sat_inc(s_userk, rx_valid_i && cls == USERK);
            s_idle  <= sat_inc(s_idle,  rx_valid_i && cls == IDLE);
            s_ctrl  <= sat_inc(s_ctrl,  rx_valid_i && cls == CTRL);
            s_bad   <= sat_inc(s_bad,   rx_valid_i && cls == BAD);
            s_drop  <= sat_inc(s_drop,  drop);
        end
    end

    assign stat_data_o  = s_data;
    assign stat_userk_o = s_userk;
    assign stat_idle_o  = s_idle;
    assign stat_ctrl_o  = s_ctrl;
    assign stat_bad_o   = s_bad;
    assign stat_drop_o  = s_drop;
`endif

endmodule
